// File: rtl/harvard_bus_bridge.sv
// ---------------------------------------------------------------------------
// harvard_bus_bridge
//
// Serialises a CPU's separate instruction and data ports onto one memory bus.
// Each instruction runs FETCH -> EVAL -> [DATA] -> STEP. The CPU advances only
// on the single-cycle clk_enable pulse issued in STEP. A transfer that stalls
// for TIMEOUT consecutive waitrequest cycles is abandoned: the sticky
// bus_error flag is set and the bridge parks in HALT until reset.
//
// Optional feature macro: BRIDGE_BYTE_SWAP_EN
//   When defined, read data is byte-reversed before it is captured and write
//   data is byte-reversed on its way to the bus. When undefined, data passes
//   through unmodified.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   instr_address    CPU fetch address
//   instr_readdata   captured instruction word
//   data_address     CPU load/store address
//   data_read        CPU load request (sampled in EVAL)
//   data_write       CPU store request (sampled in EVAL, wins over read)
//   data_writedata   CPU store data
//   data_readdata    captured load data, held until the next completed load
//   active           CPU running flag, 0 sends the bridge to HALT from EVAL
//   clk_enable       one-cycle CPU advance pulse
//   bus_address      word-aligned bus address
//   bus_read         bus read strobe
//   bus_write        bus write strobe
//   bus_writedata    bus store data
//   bus_byteenable   byte lanes, all-on while a strobe is asserted
//   bus_waitrequest  slave stall
//   bus_readdata     bus read data
//   bus_error        sticky transfer-timeout flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset release, nothing driven
// FETCH | instruction read on the bus until waitrequest drops
// EVAL  | CPU decodes the new instruction, bridge samples read/write/active
// DATA  | load or store on the bus until waitrequest drops
// STEP  | clk_enable pulse, CPU advances
// HALT  | terminal after timeout or active=0, left only by reset
// ---------------------------------------------------------------------------
module harvard_bus_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    input  logic        active,
    output logic        clk_enable,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EVAL  = 3'd2,
        DATA  = 3'd3,
        STEP  = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_inc;
    logic        timeout_hit;
    logic        data_is_write;
    logic        unused_addr_bits;

    function automatic logic [31:0] lane_swap(input logic [31:0] w);
`ifdef BRIDGE_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Bus addresses are word addresses; the CPU's byte offset is dropped.
    assign unused_addr_bits = ^{instr_address[1:0], data_address[1:0]};

    // Saturating wait count as it would read after this stalled cycle.
    assign wait_inc    = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
    assign timeout_hit = ({24'd0, wait_inc} >= TIMEOUT_U);

    // The CPU updates instr_address on the same edge that ends STEP, so the
    // fetch address has to follow the live input during FETCH rather than a
    // copy taken on the way in. Address and store data are therefore decoded
    // from the registered state; both read as zero outside a transfer.
    always_comb begin
        bus_address   = 32'd0;
        bus_writedata = 32'd0;
        case (state)
            FETCH: bus_address = {instr_address[31:2], 2'b00};
            DATA: begin
                bus_address = {data_address[31:2], 2'b00};
                if (data_is_write) begin
                    bus_writedata = lane_swap(data_writedata);
                end
            end
            default: begin
                bus_address   = 32'd0;
                bus_writedata = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wait_cnt       <= 8'd0;
            data_is_write  <= 1'b0;
            instr_readdata <= 32'd0;
            data_readdata  <= 32'd0;
            clk_enable     <= 1'b0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_byteenable <= 4'b0000;
            bus_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= FETCH;
                    wait_cnt       <= 8'd0;
                    bus_read       <= 1'b1;
                    bus_byteenable <= 4'b1111;
                end

                FETCH: begin
                    if (!bus_waitrequest) begin
                        instr_readdata <= lane_swap(bus_readdata);
                        bus_read       <= 1'b0;
                        bus_byteenable <= 4'b0000;
                        state          <= EVAL;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (timeout_hit) begin
                            bus_error      <= 1'b1;
                            bus_read       <= 1'b0;
                            bus_byteenable <= 4'b0000;
                            state          <= HALT;
                        end
                    end
                end

                EVAL: begin
                    if (!active) begin
                        state <= HALT;
                    end else if (data_write || data_read) begin
                        // A simultaneous read and write is treated as a store.
                        state          <= DATA;
                        wait_cnt       <= 8'd0;
                        data_is_write  <= data_write;
                        bus_write      <= data_write;
                        bus_read       <= ~data_write;
                        bus_byteenable <= 4'b1111;
                    end else begin
                        state      <= STEP;
                        clk_enable <= 1'b1;
                    end
                end

                DATA: begin
                    if (!bus_waitrequest) begin
                        if (!data_is_write) begin
                            data_readdata <= lane_swap(bus_readdata);
                        end
                        bus_read       <= 1'b0;
                        bus_write      <= 1'b0;
                        bus_byteenable <= 4'b0000;
                        clk_enable     <= 1'b1;
                        state          <= STEP;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (timeout_hit) begin
                            bus_error      <= 1'b1;
                            bus_read       <= 1'b0;
                            bus_write      <= 1'b0;
                            bus_byteenable <= 4'b0000;
                            state          <= HALT;
                        end
                    end
                end

                STEP: begin
                    clk_enable     <= 1'b0;
                    state          <= FETCH;
                    wait_cnt       <= 8'd0;
                    bus_read       <= 1'b1;
                    bus_byteenable <= 4'b1111;
                end

                HALT: begin
                    state <= HALT;
                end

                default: begin
                    state          <= IDLE;
                    clk_enable     <= 1'b0;
                    bus_read       <= 1'b0;
                    bus_write      <= 1'b0;
                    bus_byteenable <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_harvard_bus_bridge.sv
module tb_harvard_bus_bridge;

    localparam int TB_TIMEOUT = 4;
    localparam int M_NORM = 0;
    localparam int M_DTO  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        active;
    logic        clk_enable;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;
    logic        bus_error;

    always #5 clk = ~clk;

    harvard_bus_bridge #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_readdata   (data_readdata),
        .active          (active),
        .clk_enable      (clk_enable),
        .bus_address     (bus_address),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_writedata   (bus_writedata),
        .bus_byteenable  (bus_byteenable),
        .bus_waitrequest (bus_waitrequest),
        .bus_readdata    (bus_readdata),
        .bus_error       (bus_error)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] dreg;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_pulse = 0;
    logic [31:0] model_ireg = 32'd0;
    logic [31:0] model_dreg = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] w);
`ifdef BRIDGE_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Scoreboard consumer: every clk_enable pulse retires one expected step.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset === 1'b1) begin
            chk("strobe_excl", 32'(bus_read & bus_write), 32'd0);
            if (clk_enable === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_step", 32'(clk_enable), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("instr_readdata", instr_readdata, e.instr);
                    chk("data_readdata", data_readdata, e.dreg);
                    if (e.gap != 0) chk("step_gap", 32'(cyc - last_pulse), 32'(e.gap));
                end
                last_pulse = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_zero();
        chk("rst_bus_read", 32'(bus_read), 32'd0);
        chk("rst_bus_write", 32'(bus_write), 32'd0);
        chk("rst_clk_enable", 32'(clk_enable), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_instr_readdata", instr_readdata, 32'd0);
        chk("rst_data_readdata", data_readdata, 32'd0);
        chk("rst_bus_address", bus_address, 32'd0);
        chk("rst_bus_writedata", bus_writedata, 32'd0);
        chk("rst_bus_byteenable", 32'(bus_byteenable), 32'd0);
    endtask

    // Asserts reset from wherever the DUT is, releases it just after a rising
    // edge and returns at the falling edge of the first FETCH cycle.
    task automatic apply_reset();
        chk("sb_empty_at_reset", 32'(sb.size()), 32'd0);
        reset = 1'b0;
        #1;
        check_zero();
        model_ireg = 32'd0;
        model_dreg = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("idle_bus_read", 32'(bus_read), 32'd0);
        chk("idle_clk_enable", 32'(clk_enable), 32'd0);
        @(negedge clk);
        chk("first_fetch_read", 32'(bus_read), 32'd1);
        chk("first_fetch_be", 32'(bus_byteenable), 32'hF);
    endtask

    task automatic hold_halt(input int n, input logic err);
        for (int i = 0; i < n; i++) begin
            chk("halt_bus_read", 32'(bus_read), 32'd0);
            chk("halt_bus_write", 32'(bus_write), 32'd0);
            chk("halt_clk_enable", 32'(clk_enable), 32'd0);
            chk("halt_be", 32'(bus_byteenable), 32'd0);
            chk("halt_bus_error", 32'(bus_error), 32'(err));
            chk("halt_instr", instr_readdata, model_ireg);
            chk("halt_data", data_readdata, model_dreg);
            @(negedge clk);
        end
    endtask

    // Called at a falling edge with the DUT in FETCH; plays CPU and bus slave
    // for one instruction and returns at the falling edge of the next FETCH.
    task automatic do_instr(input logic [31:0] pc, input logic [31:0] insn,
                            input logic rd, input logic wr,
                            input logic [31:0] daddr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int fwait,
                            input int dwait, input int gap, input int mode);
        exp_t        e;
        logic [31:0] exp_d;
        exp_d = (rd && !wr) ? swap32(rdata) : model_dreg;
        if (mode == M_NORM) begin
            e.instr = swap32(insn);
            e.dreg  = exp_d;
            e.gap   = gap;
            sb.push_back(e);
        end
        instr_address = pc;
        data_read     = 1'b0;
        data_write    = 1'b0;
        active        = 1'b1;
        bus_readdata  = insn;
        for (int i = 0; i <= fwait; i++) begin
            bus_waitrequest = (i < fwait);
            #1;
            chk("fetch_read", 32'(bus_read), 32'd1);
            chk("fetch_write", 32'(bus_write), 32'd0);
            chk("fetch_addr", bus_address, {pc[31:2], 2'b00});
            chk("fetch_be", 32'(bus_byteenable), 32'hF);
            chk("fetch_clken", 32'(clk_enable), 32'd0);
            @(negedge clk);
        end
        model_ireg = swap32(insn);
        chk("eval_read", 32'(bus_read), 32'd0);
        chk("eval_write", 32'(bus_write), 32'd0);
        chk("eval_be", 32'(bus_byteenable), 32'd0);
        chk("eval_clken", 32'(clk_enable), 32'd0);
        chk("eval_instr", instr_readdata, model_ireg);
        data_read      = rd;
        data_write     = wr;
        data_address   = daddr;
        data_writedata = wdata;
        if (mode == M_HALT) active = 1'b0;
        @(negedge clk);
        if (mode == M_HALT) begin
            active          = 1'b1;
            bus_waitrequest = 1'b0;
            hold_halt(8, 1'b0);
            return;
        end
        if (rd || wr) begin
            if (mode == M_DTO) begin
                bus_waitrequest = 1'b1;
                bus_readdata    = rdata;
                for (int i = 0; i < TB_TIMEOUT; i++) begin
                    #1;
                    chk("dto_read", 32'(bus_read), 32'd1);
                    chk("dto_error_low", 32'(bus_error), 32'd0);
                    @(negedge clk);
                end
                chk("dto_error", 32'(bus_error), 32'd1);
                chk("dto_read_dropped", 32'(bus_read), 32'd0);
                bus_waitrequest = 1'b0;
                hold_halt(8, 1'b1);
                return;
            end
            for (int i = 0; i <= dwait; i++) begin
                bus_waitrequest = (i < dwait);
                bus_readdata    = (i < dwait) ? 32'hF00DF00D : rdata;
                #1;
                chk("data_addr", bus_address, {daddr[31:2], 2'b00});
                chk("data_write", 32'(bus_write), 32'(wr));
                chk("data_read", 32'(bus_read), 32'(rd & ~wr));
                chk("data_wdata", bus_writedata, wr ? swap32(wdata) : 32'd0);
                chk("data_be", 32'(bus_byteenable), 32'hF);
                chk("data_clken", 32'(clk_enable), 32'd0);
                @(negedge clk);
            end
            model_dreg = exp_d;
        end
        chk("step_clken", 32'(clk_enable), 32'd1);
        chk("step_read", 32'(bus_read), 32'd0);
        chk("step_write", 32'(bus_write), 32'd0);
        chk("step_be", 32'(bus_byteenable), 32'd0);
        @(negedge clk);
    endtask

    task automatic fetch_timeout(input logic [31:0] pc);
        instr_address   = pc;
        data_read       = 1'b0;
        data_write      = 1'b0;
        bus_waitrequest = 1'b1;
        bus_readdata    = 32'h0BADF00D;
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            #1;
            chk("fto_read", 32'(bus_read), 32'd1);
            chk("fto_error_low", 32'(bus_error), 32'd0);
            @(negedge clk);
        end
        chk("fto_error", 32'(bus_error), 32'd1);
        chk("fto_read_dropped", 32'(bus_read), 32'd0);
        chk("fto_instr_kept", instr_readdata, model_ireg);
        bus_waitrequest = 1'b0;
        hold_halt(8, 1'b1);
    endtask

    initial begin
        reset           = 1'b0;
        instr_address   = 32'hBFC00000;
        data_address    = 32'd0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_writedata  = 32'd0;
        active          = 1'b1;
        bus_waitrequest = 1'b1;
        bus_readdata    = 32'h24020005;

        apply_reset();
        #1 chk("stalled_fetch_addr", bus_address, 32'hBFC00000);
        @(negedge clk);
        chk("stalled_fetch_read", 32'(bus_read), 32'd1);
        apply_reset();

        do_instr(32'hBFC00000, 32'h24020005, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, M_NORM);
        do_instr(32'hBFC00004, 32'h24030007, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 0, 0, 3, M_NORM);
        do_instr(32'hBFC00008, 32'h00431020, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 0, 0, 3, M_NORM);
        do_instr(32'hBFC0000C, 32'hAC021006, 1'b0, 1'b1, 32'h00001006, 32'hDEADBEEF, 32'd0, 0, 3, 7, M_NORM);
        do_instr(32'hBFC00010, 32'h8C041000, 1'b1, 1'b0, 32'h00001000, 32'd0, 32'h11223344, 0, 0, 4, M_NORM);
        do_instr(32'hBFC00014, 32'h00852021, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 2, 0, 5, M_NORM);
        do_instr(32'hBFC00018, 32'hAC052002, 1'b1, 1'b1, 32'h00002002, 32'h01020304, 32'hFFFFFFFF, 0, 1, 5, M_NORM);
        do_instr(32'hBFC0001C, 32'h8C063000, 1'b1, 1'b0, 32'h00003003, 32'd0, 32'hA5A50F0F, 1, 2, 7, M_NORM);
        fetch_timeout(32'hBFC00020);

        apply_reset();
        do_instr(32'h00400000, 32'h8C070010, 1'b1, 1'b0, 32'h00000010, 32'd0, 32'hCAFEF00D, 0, 0, 0, M_NORM);
        do_instr(32'h00400004, 32'h8C080020, 1'b1, 1'b0, 32'h00000020, 32'd0, 32'h12345678, 0, 0, 0, M_DTO);

        apply_reset();
        do_instr(32'h00500000, 32'h3C011234, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, M_NORM);
        do_instr(32'h00500004, 32'h8C090000, 1'b1, 1'b0, 32'h00000040, 32'd0, 32'h55555555, 0, 0, 0, M_HALT);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
